fp16_accum_seq: RTL and testbench

//  Sequencer/accumulator that feeds the team's combinational FP16 adder.

---
 rtl/fp16_accum_seq.sv | 118 +++++++++++
 tb/tb_fp16_accum_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_accum_seq.sv
// Sequencer/accumulator feeding an external combinational FP16 adder.
// It reduces a stream of FP16 operands into one sum per vector, ending at LEN elements or on in_last.
module fp16_accum_seq #(
  parameter int LEN   = 8,
  parameter int CNT_W = $clog2(LEN+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_out,
  input  logic             add_valid,
  output logic [15:0]      out_data,
  output logic             out_nan,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, DONE} state_e;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nan_q, nan_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_nan_q, out_nan_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             beat;
  logic [CNT_W-1:0] cnt_inc;
  logic [15:0]      acc_nxt;
  logic             nan_nxt;
  logic             in_is_nan;

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign out_data  = out_data_q;
  assign out_nan   = out_nan_q;
  assign out_count = out_count_q;
  assign out_valid = (state_q == DONE);

  assign in_is_nan = (in_data[14:10] == 5'h1F) & (|in_data[9:0]);
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    nan_d       = nan_q;
    out_data_d  = out_data_q;
    out_nan_d   = out_nan_q;
    out_count_d = out_count_q;
    in_ready    = (state_q == ACCUM);
    beat        = in_valid & in_ready;

    // First element bypasses the adder so a leading -x is not turned into +0 + -x.
    if (cnt_q == '0) begin
      acc_nxt = in_data;
      nan_nxt = in_is_nan;
    end else begin
      acc_nxt = add_out;
      nan_nxt = nan_q | ~add_valid;
    end

    case (state_q)
      ACCUM: begin
        if (beat) begin
          acc_d = acc_nxt;
          nan_d = nan_nxt;
          cnt_d = cnt_inc;
          if (in_last || (cnt_inc == LEN_C)) begin
            state_d     = DONE;
            out_data_d  = acc_nxt;
            out_nan_d   = nan_nxt;
            out_count_d = cnt_inc;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          nan_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      out_data_q  <= '0;
      out_nan_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      nan_q       <= nan_d;
      out_data_q  <= out_data_d;
      out_nan_q   <= out_nan_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// Bench for fp16_accum_seq with LEN=4 and a behavioural FP16 adder standing in for the team adder.
// Expected results are queued at issue time and checked by a separate monitor on each result handshake.
module tb_fp16_accum_seq;
  localparam int LEN   = 4;
  localparam int CNT_W = $clog2(LEN+1);

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [15:0]      add_a, add_b, add_out;
  logic             add_valid;
  logic [15:0]      out_data;
  logic             out_nan;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        chk_data;
    logic        nan;
    int          count;
  } exp_t;
  exp_t sb[$];

  fp16_accum_seq #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_out(add_out), .add_valid(add_valid),
    .out_data(out_data), .out_nan(out_nan), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural FP16 adder: truncating, NaN -> 0x7E00 with valid low.
  function automatic logic [16:0] fadd(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a, b, t;
    logic [14:0] ma, mb, m;
    int ea, eb, e, sh;
    logic a_nan, b_nan;
    a_nan = (a_in[14:10] == 5'h1F) && (a_in[9:0] != 0);
    b_nan = (b_in[14:10] == 5'h1F) && (b_in[9:0] != 0);
    if (a_nan || b_nan) return {1'b0, 16'h7E00};
    if (a_in[14:10] == 5'h1F) return {1'b1, a_in};
    if (b_in[14:10] == 5'h1F) return {1'b1, b_in};
    a = a_in; b = b_in;
    if (b[14:0] > a[14:0]) begin t = a; a = b; b = t; end
    ea = (a[14:10] == 0) ? 1 : int'(a[14:10]);
    eb = (b[14:10] == 0) ? 1 : int'(b[14:10]);
    ma = {1'b0, (a[14:10] != 0), a[9:0], 3'b000};
    mb = {1'b0, (b[14:10] != 0), b[9:0], 3'b000};
    sh = ea - eb;
    mb = (sh > 14) ? 15'd0 : (mb >> sh);
    m  = (a[15] == b[15]) ? (ma + mb) : (ma - mb);
    if (m == 0) return {1'b1, 16'h0000};
    e = ea;
    if (m[14]) begin m = m >> 1; e = e + 1; end
    while (!m[13] && e > 1) begin m = m << 1; e = e - 1; end
    if (!m[13]) e = 0;
    if (e >= 31) return {1'b1, a[15], 5'h1F, 10'h000};
    return {1'b1, a[15], 5'(e), m[12:3]};
  endfunction

  always_comb {add_valid, add_out} = fadd(add_a, add_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare on every result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got data %0h count %0d, expected none", out_data, out_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_nan", 32'(out_nan), 32'(e.nan));
        chk("out_count", 32'(out_count), 32'(e.count));
      end
    end
  end

  task automatic expect_res(input logic [15:0] d, input logic cd, input logic n, input int c);
    exp_t e;
    e.data = d; e.chk_data = cd; e.nan = n; e.count = c;
    sb.push_back(e);
  endtask

  // Present one operand and hold it until accepted (bounded).
  task automatic send(input logic [15:0] d, input logic last);
    logic ok;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout: got no accept for %0h, expected accept within 50 cycles", d);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_add_a",     32'(add_a),     0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Four ones, LEN termination.
    expect_res(16'h4400, 1, 0, 4);
    for (int i = 0; i < 4; i++) send(16'h3C00, 1'b0);
    @(negedge clk);
    chk("len_out_valid", 32'(out_valid), 1);
    chk("len_in_ready",  32'(in_ready),  0);
    @(posedge clk); #1;

    // 1 + 2 with in_last.
    expect_res(16'h4200, 1, 0, 2);
    send(16'h3C00, 1'b0); send(16'h4000, 1'b1);
    @(posedge clk); #1;

    // Single negative element passes through unchanged.
    expect_res(16'hC500, 1, 0, 1);
    send(16'hC500, 1'b1);
    @(posedge clk); #1;

    // NaN in the middle is sticky.
    expect_res(16'h0000, 0, 1, 4);
    send(16'h3C00, 1'b0); send(16'h7E00, 1'b0); send(16'h4000, 1'b0); send(16'h4000, 1'b0);
    @(posedge clk); #1;

    // Back-pressure: hold DONE for 5 cycles with a pending operand upstream.
    out_ready = 1'b0;
    expect_res(16'h4400, 1, 0, 2);
    send(16'h4000, 1'b0); send(16'h4000, 1'b1);
    expect_res(16'h3C00, 1, 0, 1);
    in_valid = 1'b1; in_data = 16'h3C00; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready",  32'(in_ready),  0);
      chk("hold_out_data",  32'(out_data),  32'h4400);
      chk("hold_out_count", 32'(out_count), 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_in_ready",  32'(in_ready),  1);
    chk("post_hs_add_a",     32'(add_a),     0);
    chk("post_hs_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset mid-vector discards the partial sum.
    send(16'h4000, 1'b0); send(16'h4000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data",  32'(out_data),  0);
    chk("midrst_out_count", 32'(out_count), 0);
    chk("midrst_out_nan",   32'(out_nan),   0);
    chk("midrst_add_a",     32'(add_a),     0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    expect_res(16'h4800, 1, 0, 4);
    for (int i = 0; i < 4; i++) send(16'h4000, 1'b0);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
